pam_gray_demapper: RTL and testbench

//   Parametrised successor to the 2-bit gray demapper on the RX/TX symbol path. Accepts PAM-2^BITS_PER_SYM

---
 rtl/pam_gray_demapper.sv | 135 +++++++++++++
 tb/tb_pam_gray_demapper.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pam_gray_demapper.sv
// pam_gray_demapper
//   Takes PAM-2^BITS_PER_SYM symbols over a ready/valid handshake, buffers them
//   in a small FIFO, optionally gray-decodes each symbol as it is loaded into
//   the output shifter, and serialises the decoded bits one per cycle.
//   Backpressure is honoured on both the symbol side and the bit side.
//
// Parameters
//   BITS_PER_SYM  bits per symbol (1..8)
//   FIFO_DEPTH    symbol FIFO entries (power of two, >= 2)
//   MSB_FIRST     1: serialise decoded MSB first, 0: LSB first
//
// Ports
//   clk              rising-edge clock
//   rstn             asynchronous active-low reset
//   gray_en          1: gray-decode at shifter load, 0: pass binary through
//   symbol_in        raw symbol
//   symbol_in_valid  symbol_in is valid this cycle
//   symbol_in_ready  FIFO can accept a symbol (registered level only)
//   data_out         serial decoded bit
//   data_out_valid   data_out is valid
//   data_out_ready   downstream consumes data_out this cycle
//   fifo_level       symbols held in the FIFO, not counting the shifter

module pam_gray_demapper #(
  parameter int BITS_PER_SYM = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          gray_en,
  input  logic [BITS_PER_SYM-1:0]       symbol_in,
  input  logic                          symbol_in_valid,
  output logic                          symbol_in_ready,
  output logic                          data_out,
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BITS_PER_SYM + 1);
  localparam logic [PW:0]   LEVEL_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(BITS_PER_SYM);

  logic [BITS_PER_SYM-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic                    in_active;
  logic [BITS_PER_SYM-1:0] shift_reg;
  logic [CW-1:0]           count;
  logic                    push;
  logic                    pop;
  logic                    advance;
  logic                    fifo_empty;

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [BITS_PER_SYM-1:0] gray_decode(
    input logic [BITS_PER_SYM-1:0] g,
    input logic                    en
  );
    logic [BITS_PER_SYM-1:0] b;
    b = g;
    if (en) begin
      for (int i = BITS_PER_SYM - 2; i >= 0; i--) begin
        b[i] = b[i+1] ^ g[i];
      end
    end
    return b;
  endfunction

  // Ready is held low during reset and rises on the first edge after release,
  // so it only ever depends on registered state.
  assign symbol_in_ready = in_active && (fifo_level != LEVEL_FULL);
  assign fifo_empty      = (fifo_level == '0);
  assign push            = symbol_in_valid && symbol_in_ready;
  assign data_out_valid  = (count != '0);
  assign advance         = data_out_valid && data_out_ready;
  // Reload on the last bit's consume so consecutive symbols leave no bubble.
  assign pop             = !fifo_empty &&
                           ((count == '0) || ((count == CW'(1)) && advance));
  assign data_out        = MSB_FIRST ? shift_reg[BITS_PER_SYM-1] : shift_reg[0];

  // Symbol storage; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= symbol_in;
    end
  end

  // FIFO pointers, occupancy and the input-enable flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      in_active  <= 1'b0;
    end else begin
      in_active <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_level <= fifo_level + 1'b1;
      end else if (pop && !push) begin
        fifo_level <= fifo_level - 1'b1;
      end
    end
  end

  // Output shifter. The final bit of a symbol is not shifted out, so data_out
  // keeps its last value when the stream underflows.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_reg <= '0;
      count     <= '0;
    end else if (pop) begin
      shift_reg <= gray_decode(mem[rd_ptr], gray_en);
      count     <= CNT_LOAD;
    end else if (advance) begin
      count <= count - 1'b1;
      if (count != CW'(1)) begin
        if (MSB_FIRST) begin
          shift_reg <= shift_reg << 1;
        end else begin
          shift_reg <= shift_reg >> 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pam_gray_demapper.sv
// tb_pam_gray_demapper
//   Self-checking bench for pam_gray_demapper. One instance uses the default
//   PAM4 / MSB-first configuration, a second uses 3-bit symbols LSB-first.
//   Inputs change on the falling edge, outputs are sampled on the falling edge.

module tb_pam_gray_demapper;

  logic       clk;
  logic       rstn;

  logic       gray_en;
  logic [1:0] sym;
  logic       sv;
  logic       sr;
  logic       dout;
  logic       dv;
  logic       dr;
  logic [2:0] lvl;

  logic       g3;
  logic [2:0] sym3;
  logic       sv3;
  logic       sr3;
  logic       dout3;
  logic       dv3;
  logic       dr3;
  logic [2:0] lvl3;

  int checks = 0;
  int errors = 0;

  pam_gray_demapper #(.BITS_PER_SYM(2), .FIFO_DEPTH(4), .MSB_FIRST(1'b1)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .gray_en         (gray_en),
    .symbol_in       (sym),
    .symbol_in_valid (sv),
    .symbol_in_ready (sr),
    .data_out        (dout),
    .data_out_valid  (dv),
    .data_out_ready  (dr),
    .fifo_level      (lvl)
  );

  pam_gray_demapper #(.BITS_PER_SYM(3), .FIFO_DEPTH(4), .MSB_FIRST(1'b0)) dut3 (
    .clk             (clk),
    .rstn            (rstn),
    .gray_en         (g3),
    .symbol_in       (sym3),
    .symbol_in_valid (sv3),
    .symbol_in_ready (sr3),
    .data_out        (dout3),
    .data_out_valid  (dv3),
    .data_out_ready  (dr3),
    .fifo_level      (lvl3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode: binary value is the XOR of the gray code with all of
  // its right shifts.
  function automatic int gray2bin(input int g, input bit en);
    int b;
    b = g;
    if (en) begin
      for (int k = 1; k < 8; k++) b = b ^ (g >> k);
    end
    return b;
  endfunction

  task automatic fail(input string name, input int act, input int exp);
    errors++;
    if (errors <= 60) $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    sv = 1'b0; dr = 1'b0; sym = '0; gray_en = 1'b1;
    sv3 = 1'b0; dr3 = 1'b0; sym3 = '0; g3 = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (dv !== 1'b0)   fail("reset_valid", dv, 0);
    checks++; if (dout !== 1'b0) fail("reset_data", dout, 0);
    checks++; if (lvl !== 3'd0)  fail("reset_level", lvl, 0);
    checks++; if (sr !== 1'b0)   fail("reset_ready_low", sr, 0);
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (sr !== 1'b1)   fail("ready_after_release", sr, 1);
    checks++; if (lvl !== 3'd0)  fail("level_after_release", lvl, 0);
    checks++; if (dv !== 1'b0)   fail("valid_after_release", dv, 0);
  endtask

  task automatic test_pam4_sequence();
    int syms[4] = '{0, 1, 3, 2};
    bit ebits[8] = '{0, 0, 0, 1, 1, 0, 1, 1};
    bit exp_v;
    do_reset();
    gray_en = 1'b1; dr = 1'b1;
    for (int c = 0; c < 11; c++) begin
      sv  = (c < 4);
      sym = (c < 4) ? 2'(syms[c]) : 2'b00;
      if (c < 4) begin
        checks++; if (sr !== 1'b1) fail("seq_ready", sr, 1);
      end
      @(posedge clk); @(negedge clk);
      exp_v = (c >= 1 && c <= 8);
      checks++; if (dv !== exp_v) fail("seq_valid", dv, exp_v);
      if (exp_v) begin
        checks++; if (dout !== ebits[c-1]) fail("seq_bit", dout, ebits[c-1]);
      end
    end
    sv = 1'b0;
  endtask

  task automatic test_bits3();
    int b;
    bit exp_v;
    do_reset();
    dr3 = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      g3 = (pass == 0);
      b  = gray2bin(6, g3);
      for (int c = 0; c < 5; c++) begin
        sv3  = (c == 0);
        sym3 = 3'b110;
        @(posedge clk); @(negedge clk);
        exp_v = (c >= 1 && c <= 3);
        checks++; if (dv3 !== exp_v) fail("bits3_valid", dv3, exp_v);
        if (exp_v) begin
          checks++;
          if (dout3 !== bit'((b >> (c - 1)) & 1)) fail("bits3_bit", dout3, (b >> (c - 1)) & 1);
        end
      end
    end
    sv3 = 1'b0;
  endtask

  task automatic test_backpressure();
    int  fill[4] = '{1, 3, 0, 2};
    bit  exp_q[$];
    int  b;
    int  guard;
    do_reset();
    gray_en = 1'b1; dr = 1'b1;
    // First symbol 11 decodes to 10; consume its first bit, then stall.
    sv = 1'b1; sym = 2'b11;
    @(posedge clk); @(negedge clk);
    sv = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (dout !== 1'b1) fail("bp_first_bit", dout, 1);
    @(posedge clk); @(negedge clk);
    dr = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) begin
      sv = 1'b1; sym = 2'(fill[i]);
      checks++; if (sr !== 1'b1) fail("bp_fill_ready", sr, 1);
      b = gray2bin(fill[i], 1'b1);
      exp_q.push_back(bit'((b >> 1) & 1));
      exp_q.push_back(bit'(b & 1));
      @(posedge clk); @(negedge clk);
    end
    // Offer one more symbol while full; it must be refused.
    sym = 2'b11;
    for (int i = 0; i < 10; i++) begin
      checks++; if (lvl !== 3'd4)  fail("bp_level_full", lvl, 4);
      checks++; if (sr !== 1'b0)   fail("bp_ready_full", sr, 0);
      checks++; if (dv !== 1'b1)   fail("bp_valid_hold", dv, 1);
      checks++; if (dout !== 1'b0) fail("bp_data_hold", dout, 0);
      @(posedge clk); @(negedge clk);
    end
    sv = 1'b0; dr = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 30) begin
      if (dv) begin
        checks++;
        if (dout !== exp_q[0]) fail("bp_drain_bit", dout, exp_q[0]);
        void'(exp_q.pop_front());
      end
      @(posedge clk); @(negedge clk);
      guard++;
    end
    checks++; if (guard >= 30) fail("bp_drain_timeout", guard, 30);
    checks++; if (dv !== 1'b0)  fail("bp_end_valid", dv, 0);
    checks++; if (lvl !== 3'd0) fail("bp_end_level", lvl, 0);
  endtask

  task automatic test_underflow();
    bit exp_v;
    do_reset();
    gray_en = 1'b1; dr = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sv = (c == 0); sym = 2'b01;
      @(posedge clk); @(negedge clk);
      exp_v = (c == 1 || c == 2);
      checks++; if (dv !== exp_v) fail("uf_valid", dv, exp_v);
      if (c == 1) begin checks++; if (dout !== 1'b0) fail("uf_bit0", dout, 0); end
      if (c >= 2) begin checks++; if (dout !== 1'b1) fail("uf_bit1_hold", dout, 1); end
    end
    sv = 1'b0;
  endtask

  task automatic test_async_reset();
    int s[3] = '{2, 1, 3};
    bit exp_v;
    do_reset();
    gray_en = 1'b1; dr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sv = 1'b1; sym = 2'(s[i]);
      @(posedge clk); @(negedge clk);
    end
    sv = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (lvl !== 3'd2)  fail("ar_pre_level", lvl, 2);
    checks++; if (dv !== 1'b1)   fail("ar_pre_valid", dv, 1);
    checks++; if (dout !== 1'b1) fail("ar_pre_data", dout, 1);
    #2 rstn = 1'b0;
    #1;
    checks++; if (dv !== 1'b0)   fail("ar_valid", dv, 0);
    checks++; if (dout !== 1'b0) fail("ar_data", dout, 0);
    checks++; if (lvl !== 3'd0)  fail("ar_level", lvl, 0);
    checks++; if (sr !== 1'b0)   fail("ar_ready", sr, 0);
    @(negedge clk);
    checks++; if (sr !== 1'b0)   fail("ar_ready_held", sr, 0);
    rstn = 1'b1;
    @(negedge clk);
    dr = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sv = (c == 0); sym = 2'b10;
      @(posedge clk); @(negedge clk);
      exp_v = (c == 1 || c == 2);
      checks++; if (dv !== exp_v) fail("ar_post_valid", dv, exp_v);
      if (exp_v) begin checks++; if (dout !== 1'b1) fail("ar_post_bit", dout, 1); end
    end
    checks++; if (lvl !== 3'd0) fail("ar_post_level", lvl, 0);
    sv = 1'b0;
  endtask

  task automatic test_random(input bit en, input int nsym);
    bit exp_q[$];
    int m_level;
    int m_rem;
    int pushed;
    int guard;
    int bound;
    int b;
    bit consume;
    bit push;
    bit load;
    do_reset();
    gray_en = en;
    m_level = 0; m_rem = 0; pushed = 0; guard = 0;
    bound = nsym * 4;
    while ((pushed < nsym || m_rem != 0 || m_level != 0) && guard < bound) begin
      checks++; if (dv !== (m_rem != 0))        fail("rnd_valid", dv, m_rem != 0);
      checks++; if (lvl !== 3'(m_level))        fail("rnd_level", lvl, m_level);
      checks++; if (sr !== (m_level != 4))      fail("rnd_ready", sr, m_level != 4);
      sv  = (pushed < nsym) && ($urandom_range(0, 9) < 7);
      sym = 2'($urandom);
      dr  = ($urandom_range(0, 9) < 8);
      consume = (m_rem != 0) && dr;
      push    = sv && (m_level != 4);
      if (consume) begin
        checks++;
        if (exp_q.size() == 0) fail("rnd_extra_bit", dout, -1);
        else begin
          if (dout !== exp_q[0]) fail("rnd_bit", dout, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
      if (push) begin
        b = gray2bin(int'(sym), en);
        exp_q.push_back(bit'((b >> 1) & 1));
        exp_q.push_back(bit'(b & 1));
        pushed++;
      end
      load    = (m_level > 0) && (m_rem == 0 || (m_rem == 1 && consume));
      m_rem   = load ? 2 : m_rem - int'(consume);
      m_level = m_level + int'(push) - int'(load);
      @(posedge clk); @(negedge clk);
      guard++;
    end
    sv = 1'b0;
    checks++; if (guard >= bound)    fail("rnd_timeout", guard, bound);
    checks++; if (exp_q.size() != 0) fail("rnd_leftover_bits", exp_q.size(), 0);
    checks++; if (dv !== 1'b0)       fail("rnd_end_valid", dv, 0);
  endtask

  initial begin
    rstn = 1'b0;
    sv = 1'b0; dr = 1'b0; sym = '0; gray_en = 1'b1;
    sv3 = 1'b0; dr3 = 1'b0; sym3 = '0; g3 = 1'b1;
    @(negedge clk);
    test_reset();
    test_pam4_sequence();
    test_bits3();
    test_backpressure();
    test_underflow();
    test_async_reset();
    test_random(1'b1, 5000);
    test_random(1'b0, 5000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
